// File: rtl/load_store_queue_pkg.sv
// ----------------------------------------------------------------------------
// load_store_queue_pkg
// Shared widths, RISC-V load/store funct3 codes, memory access size codes,
// the queue entry layout and the operand snoop helper used by the
// load/store queue.
// ----------------------------------------------------------------------------
package load_store_queue_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ROB_WIDTH  = 4;

  localparam logic [ROB_WIDTH-1:0]  ZERO_ROB  = '0;
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Defaults for the queue geometry; the top exposes them as parameters.
  localparam int LSQ_SIZE_DEFAULT  = 16;
  localparam int LSQ_WIDTH_DEFAULT = 4;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

  typedef enum logic {ST_IDLE, ST_BUSY} lsq_state_e;

  // An operand is ready when its tag is ZERO_ROB; value is then meaningful.
  typedef struct packed {
    logic [ROB_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] value;
  } operand_t;

  typedef struct packed {
    logic                  valid;
    logic                  is_store;
    logic [2:0]            funct3;
    logic [ROB_WIDTH-1:0]  rob_tag;
    logic [DATA_WIDTH-1:0] imm;
    operand_t              base;
    operand_t              data;
    logic                  committed;
  } lsq_entry_t;

  // Resolve a pending operand against both CDBs. The caller zeroes alu_tag
  // when the ALU CDB slot carries a load, so it never matches.
  function automatic operand_t snoop_operand(input operand_t              op,
                                             input logic [ROB_WIDTH-1:0]  alu_tag,
                                             input logic [DATA_WIDTH-1:0] alu_value,
                                             input logic [ROB_WIDTH-1:0]  ls_tag,
                                             input logic [DATA_WIDTH-1:0] ls_value);
    operand_t res;
    res = op;
    if (op.tag != ZERO_ROB) begin
      if (op.tag == alu_tag) begin
        res.tag   = ZERO_ROB;
        res.value = alu_value;
      end else if (op.tag == ls_tag) begin
        res.tag   = ZERO_ROB;
        res.value = ls_value;
      end
    end
    return res;
  endfunction

  // Clear the bytes above the access size so memory sees clean write data.
  function automatic logic [DATA_WIDTH-1:0] mask_store(input logic [DATA_WIDTH-1:0] d,
                                                       input logic [1:0]            size);
    case (size)
      MEM_SIZE_BYTE: return {24'b0, d[7:0]};
      MEM_SIZE_HALF: return {16'b0, d[15:0]};
      default:       return d;
    endcase
  endfunction

endpackage

// File: rtl/load_store_queue_if.sv
// ----------------------------------------------------------------------------
// load_store_queue_if
// Memory-controller bus of the load/store queue.
//   out_mem_ena / out_mem_iswrite / out_mem_addr / out_mem_data / out_mem_size
//     request from the queue, held from issue until completion.
//   in_mem_ready : one-cycle completion pulse from memory.
//   in_mem_data  : raw, right-aligned load data.
// master = queue side, slave = memory controller side.
// ----------------------------------------------------------------------------
interface load_store_queue_if;
  import load_store_queue_pkg::*;

  logic                  out_mem_ena;
  logic                  out_mem_iswrite;
  logic [DATA_WIDTH-1:0] out_mem_addr;
  logic [DATA_WIDTH-1:0] out_mem_data;
  logic [1:0]            out_mem_size;
  logic                  in_mem_ready;
  logic [DATA_WIDTH-1:0] in_mem_data;

  modport master (
    output out_mem_ena, out_mem_iswrite, out_mem_addr, out_mem_data, out_mem_size,
    input  in_mem_ready, in_mem_data
  );

  modport slave (
    input  out_mem_ena, out_mem_iswrite, out_mem_addr, out_mem_data, out_mem_size,
    output in_mem_ready, in_mem_data
  );
endinterface

// File: rtl/load_store_queue_load_extend.sv
// ----------------------------------------------------------------------------
// ls_load_extend
// Combinational load result formatter.
//   funct3 : load funct3 (LB/LH/LW/LBU/LHU)
//   raw    : right-aligned data from memory
//   value  : sign- or zero-extended 32-bit result
// ----------------------------------------------------------------------------
module ls_load_extend
  import load_store_queue_pkg::*;
(
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] raw,
  output logic [DATA_WIDTH-1:0] value
);

  always_comb begin
    case (funct3)
      LB:      value = {{24{raw[7]}}, raw[7:0]};
      LH:      value = {{16{raw[15]}}, raw[15:0]};
      LBU:     value = {24'b0, raw[7:0]};
      LHU:     value = {16'b0, raw[15:0]};
      default: value = raw;
    endcase
  end

endmodule

// File: rtl/load_store_queue.sv
// ----------------------------------------------------------------------------
// load_store_queue
// In-order load/store queue. Entries are dispatched at the tail, resolve their
// base/store-data operands by snooping the ALU CDB and the LS CDB, and issue to
// memory from the head one at a time: loads as soon as their base is ready,
// stores only once also committed by the ROB. Load results are broadcast on
// the LS CDB for one cycle. A misbranch keeps only the committed-store prefix.
// Ports:
//   clk, rst (sync, active-high), ena (global hold when low)
//   in_assignment_ena .. in_data_value : dispatch of one entry
//   in_cdb_rob_tag / in_cdb_value / in_cdb_isload : ALU CDB snoop
//   in_committed_rob_tag : store commit from the ROB
//   in_misbranch : flush uncommitted entries
//   mem : memory-controller bus (master side)
//   out_ls_cdb_rob_tag / out_ls_cdb_value : load broadcast
//   out_lsq_ok : room for at least one more dispatch
// ----------------------------------------------------------------------------
module load_store_queue
  import load_store_queue_pkg::*;
#(
  parameter int LSQ_SIZE  = LSQ_SIZE_DEFAULT,
  parameter int LSQ_WIDTH = LSQ_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  in_assignment_ena,
  input  logic                  in_is_store,
  input  logic [2:0]            in_funct3,
  input  logic [ROB_WIDTH-1:0]  in_rob_tag,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic [ROB_WIDTH-1:0]  in_base_tag,
  input  logic [DATA_WIDTH-1:0] in_base_value,
  input  logic [ROB_WIDTH-1:0]  in_data_tag,
  input  logic [DATA_WIDTH-1:0] in_data_value,
  input  logic [ROB_WIDTH-1:0]  in_cdb_rob_tag,
  input  logic [DATA_WIDTH-1:0] in_cdb_value,
  input  logic                  in_cdb_isload,
  input  logic [ROB_WIDTH-1:0]  in_committed_rob_tag,
  input  logic                  in_misbranch,
  load_store_queue_if.master    mem,
  output logic [ROB_WIDTH-1:0]  out_ls_cdb_rob_tag,
  output logic [DATA_WIDTH-1:0] out_ls_cdb_value,
  output logic                  out_lsq_ok
);

  lsq_entry_t            q [LSQ_SIZE];
  logic [LSQ_WIDTH-1:0]  head, tail;
  logic [LSQ_WIDTH:0]    count;
  lsq_state_e            state, state_next;
  logic                  squash;      // in-flight load was flushed; mute its broadcast

  lsq_entry_t            head_e;
  lsq_entry_t            new_entry;
  logic                  head_ready, issue, pop, bcast, do_dispatch, busy_load;
  logic [ROB_WIDTH-1:0]  alu_tag;
  logic [LSQ_WIDTH:0]    n_committed, keep_n;
  logic [DATA_WIDTH-1:0] ext_value;

  assign head_e      = q[head];
  assign alu_tag     = in_cdb_isload ? ZERO_ROB : in_cdb_rob_tag;
  assign out_lsq_ok  = count < (LSQ_WIDTH+1)'(LSQ_SIZE - 1);
  assign do_dispatch = ena && in_assignment_ena && out_lsq_ok && !in_misbranch;
  assign busy_load   = (state == ST_BUSY) && !head_e.is_store;
  assign head_ready  = head_e.valid && (head_e.base.tag == ZERO_ROB) &&
                       (!head_e.is_store || (head_e.data.tag == ZERO_ROB && head_e.committed));

  // ---------------- FSM: state register ----------------
  // NOTE: every clocked process uses non-blocking assignments so all
  // registers update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: each combinational output gets a default before any branch,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (ena && head_ready && !in_misbranch) state_next = ST_BUSY;
      ST_BUSY: if (ena && mem.in_mem_ready)            state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    issue = (state == ST_IDLE) && (state_next == ST_BUSY);
    pop   = (state == ST_BUSY) && (state_next == ST_IDLE);
    bcast = pop && !head_e.is_store && !squash && !in_misbranch;
  end

  // Committed stores form a prefix from head, so counting them gives the
  // length of the region that survives a misbranch. An in-flight load also
  // stays until memory completes, so its slot is retired by the normal pop.
  always_comb begin
    n_committed = '0;
    for (int i = 0; i < LSQ_SIZE; i++)
      if (q[i].valid && q[i].committed) n_committed = n_committed + 1'b1;
    keep_n = n_committed + (LSQ_WIDTH+1)'(busy_load);
  end

  // Dispatch sees the same-cycle CDBs so a value broadcast now is not missed.
  always_comb begin
    new_entry           = '0;
    new_entry.valid     = TRUE;
    new_entry.is_store  = in_is_store;
    new_entry.funct3    = in_funct3;
    new_entry.rob_tag   = in_rob_tag;
    new_entry.imm       = in_imm;
    new_entry.base      = snoop_operand('{tag: in_base_tag, value: in_base_value}, alu_tag,
                                        in_cdb_value, out_ls_cdb_rob_tag, out_ls_cdb_value);
    new_entry.data      = snoop_operand('{tag: in_data_tag, value: in_data_value}, alu_tag,
                                        in_cdb_value, out_ls_cdb_rob_tag, out_ls_cdb_value);
    new_entry.committed = FALSE;
  end

  // ---------------- entry storage ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: only the control bits are reset; payload fields are ignored
      // while an entry is invalid, so the storage needs no reset.
      for (int i = 0; i < LSQ_SIZE; i++) begin
        q[i].valid     <= FALSE;
        q[i].committed <= FALSE;
      end
    end else if (ena) begin
      for (int i = 0; i < LSQ_SIZE; i++) begin
        if (q[i].valid) begin
          q[i].base <= snoop_operand(q[i].base, alu_tag, in_cdb_value,
                                     out_ls_cdb_rob_tag, out_ls_cdb_value);
          q[i].data <= snoop_operand(q[i].data, alu_tag, in_cdb_value,
                                     out_ls_cdb_rob_tag, out_ls_cdb_value);
          if (in_committed_rob_tag != ZERO_ROB && q[i].rob_tag == in_committed_rob_tag)
            q[i].committed <= TRUE;
          if (in_misbranch && !q[i].committed && !(busy_load && LSQ_WIDTH'(i) == head))
            q[i].valid <= FALSE;
        end
      end
      if (pop)         q[head].valid <= FALSE;
      if (do_dispatch) q[tail]       <= new_entry;
    end
  end

  // ---------------- pointers and occupancy ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      squash <= FALSE;
    end else if (ena) begin
      if (pop) head <= head + 1'b1;
      if (in_misbranch) begin
        // Tail is rebuilt from the pre-pop head: a popping entry is part of keep_n.
        tail  <= head + keep_n[LSQ_WIDTH-1:0];
        count <= keep_n - (LSQ_WIDTH+1)'(pop);
      end else begin
        if (do_dispatch) tail <= tail + 1'b1;
        count <= count + (LSQ_WIDTH+1)'(do_dispatch) - (LSQ_WIDTH+1)'(pop);
      end
      if (pop)                         squash <= FALSE;
      else if (in_misbranch && busy_load) squash <= TRUE;
    end
  end

  // ---------------- memory request ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      mem.out_mem_ena     <= FALSE;
      mem.out_mem_iswrite <= FALSE;
      mem.out_mem_addr    <= ZERO_DATA;
      mem.out_mem_data    <= ZERO_DATA;
      mem.out_mem_size    <= MEM_SIZE_BYTE;
    end else if (ena) begin
      if (issue) begin
        mem.out_mem_ena     <= TRUE;
        mem.out_mem_iswrite <= head_e.is_store;
        mem.out_mem_addr    <= head_e.base.value + head_e.imm;
        mem.out_mem_data    <= mask_store(head_e.data.value, head_e.funct3[1:0]);
        mem.out_mem_size    <= head_e.funct3[1:0];
      end else if (pop) begin
        mem.out_mem_ena     <= FALSE;
      end
    end
  end

  // ---------------- load broadcast ----------------
  ls_load_extend u_load_extend (
    .funct3 (head_e.funct3),
    .raw    (mem.in_mem_data),
    .value  (ext_value)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_ls_cdb_rob_tag <= ZERO_ROB;
      out_ls_cdb_value   <= ZERO_DATA;
    end else if (ena) begin
      if (bcast) begin
        out_ls_cdb_rob_tag <= head_e.rob_tag;
        out_ls_cdb_value   <= ext_value;
      end else begin
        out_ls_cdb_rob_tag <= ZERO_ROB;
        out_ls_cdb_value   <= ZERO_DATA;
      end
    end
  end

endmodule

// File: tb/tb_load_store_queue.sv
// ----------------------------------------------------------------------------
// tb_load_store_queue
// Directed bench for load_store_queue. Expected memory requests and load
// broadcasts are queued when stimulus is driven and compared when the DUT
// issues the request / returns the result.
// ----------------------------------------------------------------------------
module tb_load_store_queue;
  import load_store_queue_pkg::*;

  logic                  clk;
  logic                  rst, ena;
  logic                  in_assignment_ena, in_is_store;
  logic [2:0]            in_funct3;
  logic [ROB_WIDTH-1:0]  in_rob_tag, in_base_tag, in_data_tag;
  logic [DATA_WIDTH-1:0] in_imm, in_base_value, in_data_value;
  logic [ROB_WIDTH-1:0]  in_cdb_rob_tag, in_committed_rob_tag;
  logic [DATA_WIDTH-1:0] in_cdb_value;
  logic                  in_cdb_isload, in_misbranch;
  logic [ROB_WIDTH-1:0]  out_ls_cdb_rob_tag;
  logic [DATA_WIDTH-1:0] out_ls_cdb_value;
  logic                  out_lsq_ok;

  load_store_queue_if mem_bus ();

  load_store_queue dut (
    .clk                  (clk),
    .rst                  (rst),
    .ena                  (ena),
    .in_assignment_ena    (in_assignment_ena),
    .in_is_store          (in_is_store),
    .in_funct3            (in_funct3),
    .in_rob_tag           (in_rob_tag),
    .in_imm               (in_imm),
    .in_base_tag          (in_base_tag),
    .in_base_value        (in_base_value),
    .in_data_tag          (in_data_tag),
    .in_data_value        (in_data_value),
    .in_cdb_rob_tag       (in_cdb_rob_tag),
    .in_cdb_value         (in_cdb_value),
    .in_cdb_isload        (in_cdb_isload),
    .in_committed_rob_tag (in_committed_rob_tag),
    .in_misbranch         (in_misbranch),
    .mem                  (mem_bus),
    .out_ls_cdb_rob_tag   (out_ls_cdb_rob_tag),
    .out_ls_cdb_value     (out_ls_cdb_value),
    .out_lsq_ok           (out_lsq_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iswrite;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [3:0]  cdb_tag;   // 0: no broadcast expected
    logic [31:0] cdb_val;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   last_wait;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic st, input logic [2:0] f3, input logic [3:0] rob,
                          input logic [31:0] imm, input logic [3:0] btag, input logic [31:0] bval,
                          input logic [3:0] dtag, input logic [31:0] dval);
    in_is_store = st;  in_funct3 = f3;  in_rob_tag = rob;  in_imm = imm;
    in_base_tag = btag; in_base_value = bval; in_data_tag = dtag; in_data_value = dval;
    in_assignment_ena = 1'b1;
    tick();
    in_assignment_ena = 1'b0;
  endtask

  task automatic expect_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] s, input logic [3:0] t, input logic [31:0] v);
    exp_t e;
    e.iswrite = w; e.addr = a; e.data = d; e.size = s; e.cdb_tag = t; e.cdb_val = v;
    exp_q.push_back(e);
  endtask

  task automatic commit(input logic [3:0] rob);
    in_committed_rob_tag = rob;
    tick();
    in_committed_rob_tag = '0;
  endtask

  task automatic cdb(input logic [3:0] t, input logic [31:0] v, input logic isload);
    in_cdb_rob_tag = t; in_cdb_value = v; in_cdb_isload = isload;
    tick();
    in_cdb_rob_tag = '0; in_cdb_value = '0; in_cdb_isload = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!mem_bus.out_mem_ena && n < 50) begin
      tick();
      n++;
    end
    last_wait = n;
    check({tag, "_req_seen"}, 32'(mem_bus.out_mem_ena), 32'd1);
    check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) cur = exp_q.pop_front();
    check({tag, "_iswrite"}, 32'(mem_bus.out_mem_iswrite), 32'(cur.iswrite));
    check({tag, "_addr"}, mem_bus.out_mem_addr, cur.addr);
    check({tag, "_size"}, 32'(mem_bus.out_mem_size), 32'(cur.size));
    if (cur.iswrite) check({tag, "_wdata"}, mem_bus.out_mem_data, cur.data);
  endtask

  task automatic respond(input logic [31:0] d, input string tag);
    mem_bus.in_mem_ready = 1'b1;
    mem_bus.in_mem_data  = d;
    tick();
    mem_bus.in_mem_ready = 1'b0;
    check({tag, "_ena_drop"}, 32'(mem_bus.out_mem_ena), 32'd0);
    check({tag, "_cdb_tag"}, 32'(out_ls_cdb_rob_tag), 32'(cur.cdb_tag));
    check({tag, "_cdb_val"}, out_ls_cdb_value, (cur.cdb_tag != 0) ? cur.cdb_val : 32'd0);
  endtask

  task automatic serve(input logic [31:0] d, input string tag);
    wait_req(tag);
    respond(d, tag);
    tick();
    check({tag, "_cdb_clear"}, 32'(out_ls_cdb_rob_tag), 32'd0);
  endtask

  function automatic logic [3:0] rob_of(input int n);
    return 4'(n % 15 + 1);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, ns, hits;
    rst = 1'b1; ena = 1'b1;
    in_assignment_ena = 0; in_is_store = 0; in_funct3 = 0; in_rob_tag = 0; in_imm = 0;
    in_base_tag = 0; in_base_value = 0; in_data_tag = 0; in_data_value = 0;
    in_cdb_rob_tag = 0; in_cdb_value = 0; in_cdb_isload = 0;
    in_committed_rob_tag = 0; in_misbranch = 0;
    mem_bus.in_mem_ready = 0; mem_bus.in_mem_data = 0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_mem_ena", 32'(mem_bus.out_mem_ena), 0);
    check("rst_mem_addr", mem_bus.out_mem_addr, 0);
    check("rst_cdb_tag", 32'(out_ls_cdb_rob_tag), 0);
    check("rst_lsq_ok", 32'(out_lsq_ok), 1);
    check("rst_count", 32'(dut.count), 0);

    // Basic LW: address 0x100 + 4, result on LS CDB one cycle after ready
    dispatch(0, LW, 4'd3, 32'd4, 4'd0, 32'h100, 4'd0, 32'd0);
    expect_req(0, 32'h104, 0, MEM_SIZE_WORD, 4'd3, 32'h12345678);
    wait_req("lw");
    check("lw_issue_latency", 32'(last_wait), 1);
    respond(32'h12345678, "lw");
    tick();
    check("lw_cdb_clear", 32'(out_ls_cdb_rob_tag), 0);

    // Byte/half extension
    dispatch(0, LB,  4'd4, 32'd0, 4'd0, 32'h200, 4'd0, 32'd0);
    expect_req(0, 32'h200, 0, MEM_SIZE_BYTE, 4'd4, 32'hFFFFFF80);
    dispatch(0, LBU, 4'd5, 32'd0, 4'd0, 32'h200, 4'd0, 32'd0);
    expect_req(0, 32'h200, 0, MEM_SIZE_BYTE, 4'd5, 32'h00000080);
    dispatch(0, LH,  4'd6, 32'd2, 4'd0, 32'h200, 4'd0, 32'd0);
    expect_req(0, 32'h202, 0, MEM_SIZE_HALF, 4'd6, 32'hFFFF8001);
    serve(32'h00000080, "lb");
    serve(32'h00000080, "lbu");
    serve(32'h00018001, "lh");

    // SW waiting on store data, then on commit; a load-flagged ALU CDB slot is ignored
    dispatch(1, SW, 4'd8, 32'd8, 4'd0, 32'h300, 4'd5, 32'd0);
    cdb(4'd5, 32'h0BAD, 1'b1);
    cdb(4'd5, 32'hDEAD, 1'b0);
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mem_bus.out_mem_ena) hits++;
    end
    check("sw_no_issue_before_commit", 32'(hits), 0);
    commit(4'd8);
    expect_req(1, 32'h308, 32'hDEAD, MEM_SIZE_WORD, 4'd0, 0);
    serve(32'd0, "sw");

    // Misbranch keeps only the committed SB; same-cycle dispatch is dropped
    dispatch(1, SB, 4'd9, 32'd1, 4'd10, 32'd0, 4'd0, 32'h1234ABCD);
    commit(4'd9);
    dispatch(0, LW, 4'd11, 32'd0, 4'd0, 32'h500, 4'd0, 32'd0);
    dispatch(1, SH, 4'd12, 32'd0, 4'd0, 32'h540, 4'd0, 32'h5555);
    check("mb_count_before", 32'(dut.count), 3);
    in_misbranch = 1'b1;
    dispatch(0, LW, 4'd13, 32'd0, 4'd0, 32'h580, 4'd0, 32'd0);
    in_misbranch = 1'b0;
    check("mb_count_after", 32'(dut.count), 1);
    cdb(4'd10, 32'h400, 1'b0);
    expect_req(1, 32'h401, 32'h000000CD, MEM_SIZE_BYTE, 4'd0, 0);
    serve(32'd0, "mb_sb");
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (mem_bus.out_mem_ena || out_ls_cdb_rob_tag != 0) hits++;
    end
    check("mb_no_more_activity", 32'(hits), 0);
    check("mb_count_end", 32'(dut.count), 0);

    // In-flight load flushed: memory completes, broadcast suppressed
    dispatch(0, LW, 4'd14, 32'd0, 4'd0, 32'h600, 4'd0, 32'd0);
    expect_req(0, 32'h600, 0, MEM_SIZE_WORD, 4'd0, 0);
    wait_req("squash");
    in_misbranch = 1'b1;
    tick();
    in_misbranch = 1'b0;
    check("squash_count_mid", 32'(dut.count), 1);
    respond(32'hFFFF, "squash");
    check("squash_count_end", 32'(dut.count), 0);

    // Fill to 15, overflow ignored, then wrap the pointers in program order
    nd = 0; ns = 0;
    for (int k = 0; k < 15; k++) begin
      dispatch(0, LW, rob_of(nd), 32'd0, 4'd0, 32'h1000 + 32'(nd) * 4, 4'd0, 32'd0);
      expect_req(0, 32'h1000 + 32'(nd) * 4, 0, MEM_SIZE_WORD, rob_of(nd), 32'hA0000000 + 32'(nd));
      nd++;
    end
    check("full_ok_low", 32'(out_lsq_ok), 0);
    dispatch(0, LW, 4'd1, 32'd0, 4'd0, 32'hFFF0, 4'd0, 32'd0);
    check("full_overflow_ignored", 32'(dut.count), 15);
    serve(32'hA0000000 + 32'(ns), "fill_pop");
    ns++;
    check("full_ok_back", 32'(out_lsq_ok), 1);
    for (int k = 0; k < 40; k++) begin
      dispatch(0, LW, rob_of(nd), 32'd0, 4'd0, 32'h1000 + 32'(nd) * 4, 4'd0, 32'd0);
      expect_req(0, 32'h1000 + 32'(nd) * 4, 0, MEM_SIZE_WORD, rob_of(nd), 32'hA0000000 + 32'(nd));
      nd++;
      serve(32'hA0000000 + 32'(ns), "wrap");
      ns++;
    end
    // Simultaneous dispatch and pop leave the count unchanged
    wait_req("simul");
    in_is_store = 0; in_funct3 = LW; in_rob_tag = rob_of(nd); in_imm = 0;
    in_base_tag = 0; in_base_value = 32'h1000 + 32'(nd) * 4; in_data_tag = 0;
    in_assignment_ena = 1'b1;
    expect_req(0, 32'h1000 + 32'(nd) * 4, 0, MEM_SIZE_WORD, rob_of(nd), 32'hA0000000 + 32'(nd));
    nd++;
    respond(32'hA0000000 + 32'(ns), "simul");
    in_assignment_ena = 1'b0;
    ns++;
    check("simul_count", 32'(dut.count), 14);
    while (ns < nd) begin
      serve(32'hA0000000 + 32'(ns), "drain");
      ns++;
    end
    check("drain_count", 32'(dut.count), 0);

    // SW captures its base from the LS CDB in the dispatch cycle
    dispatch(0, LW, 4'd7, 32'd0, 4'd0, 32'h700, 4'd0, 32'd0);
    expect_req(0, 32'h700, 0, MEM_SIZE_WORD, 4'd7, 32'h900);
    wait_req("fwd_lw");
    respond(32'h900, "fwd_lw");
    dispatch(1, SW, 4'd13, 32'h10, 4'd7, 32'd0, 4'd0, 32'h55);
    check("fwd_cdb_clear", 32'(out_ls_cdb_rob_tag), 0);
    commit(4'd13);
    expect_req(1, 32'h910, 32'h55, MEM_SIZE_WORD, 4'd0, 0);
    serve(32'd0, "fwd_sw");

    // Reset in the middle of a transaction drops the request
    dispatch(0, LW, 4'd2, 32'd0, 4'd0, 32'h800, 4'd0, 32'd0);
    expect_req(0, 32'h800, 0, MEM_SIZE_WORD, 4'd0, 0);
    wait_req("midrst");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_mem_ena", 32'(mem_bus.out_mem_ena), 0);
    check("midrst_count", 32'(dut.count), 0);
    check("midrst_ok", 32'(out_lsq_ok), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_queue.md
# load_store_queue

In-order load/store queue between the decoder, the CDB, the ROB and the memory controller. It receives memory instructions at dispatch and resolves their base and store-data operands by snooping both CDBs. Loads issue when they reach the head; stores issue only after the ROB commits them. Load results go back out on the dedicated LS CDB (`ls_cdb`), and on a misbranch every uncommitted entry is dropped.

## Interface
- `LSQ_SIZE`, default 16: number of entries; must be a power of two.
- `LSQ_WIDTH`, default 4: log2(`LSQ_SIZE`); width of the head and tail pointers.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous and active-high.
- `ena` in 1: global enable; when low, all state holds.
- `in_assignment_ena` in 1: dispatch a new entry this cycle.
- `in_is_store` in 1: entry is a store.
- `in_funct3` in 3: RISC-V funct3 of the instruction.
- `in_rob_tag` in `ROB_WIDTH`: ROB tag of the entry.
- `in_imm` in `DATA_WIDTH`: sign-extended offset.
- `in_base_tag` in `ROB_WIDTH`: base operand tag; 0 means the value is ready.
- `in_base_value` in `DATA_WIDTH`: base operand value.
- `in_data_tag` in `ROB_WIDTH`: store-data tag; 0 means the value is ready.
- `in_data_value` in `DATA_WIDTH`: store-data value.
- `in_cdb_rob_tag` in `ROB_WIDTH`: ALU CDB tag; 0 means idle.
- `in_cdb_value` in `DATA_WIDTH`: ALU CDB value.
- `in_cdb_isload` in 1: ALU CDB slot is a load; ignore it.
- `in_committed_rob_tag` in `ROB_WIDTH`: store commit from the ROB; 0 means none.
- `in_misbranch` in 1: flush request.
- `out_mem_ena` out 1: memory request valid.
- `out_mem_iswrite` out 1: request is a write.
- `out_mem_addr` out `DATA_WIDTH`: request address.
- `out_mem_data` out `DATA_WIDTH`: write data.
- `out_mem_size` out 2: 0 = byte, 1 = half, 2 = word.
- `in_mem_ready` in 1: one-cycle completion pulse from memory.
- `in_mem_data` in `DATA_WIDTH`: raw load data, right-aligned.
- `out_ls_cdb_rob_tag` out `ROB_WIDTH`: load broadcast tag; 0 means idle.
- `out_ls_cdb_value` out `DATA_WIDTH`: load broadcast value.
- `out_lsq_ok` out 1: there is room to dispatch at least one entry.

## Operation
- Circular FIFO with `head`, `tail` and `count`; indices wrap modulo `LSQ_SIZE`.
- Per-entry fields:
  - valid, is_store, funct3, rob_tag, imm;
  - base tag/value, data tag/value;
  - committed flag.
- Dispatch:
  - Written at `tail`.
  - An operand whose tag matches `in_cdb_rob_tag` (with `!in_cdb_isload`) or `out_ls_cdb_rob_tag` in the same cycle is captured as ready immediately.
- Snoop (every cycle, all valid entries):
  - A pending operand tag equal to a non-zero CDB tag takes that value and its tag is set to 0.
  - This applies to both the ALU CDB and the LS CDB.
- Commit: the entry whose `rob_tag` equals a non-zero `in_committed_rob_tag` sets its committed flag.
- FSM with two states:
  - IDLE → BUSY when the head entry is valid, its base tag is 0, and either:
    - it is a load, or
    - it is a store with data tag 0 and committed set.
  - On that transition, the memory request outputs are latched.
  - Address = base + imm, mod 2^32.
  - Size comes from `funct3[1:0]`.
  - Store data is masked to the access size.
  - BUSY → IDLE on `in_mem_ready`; the head entry is popped.
- Load result:
  - Extended by the `ls_load_extend` sub-module: LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Driven on the LS CDB for exactly one cycle.
- Misbranch:
  - Committed stores always form a prefix starting at `head`; they are kept.
  - All other entries are invalidated.
  - `tail` is set to `head` plus the number of committed entries.
  - An in-flight store completes normally.
  - An in-flight load completes on the memory side, but its broadcast is suppressed.
  - A dispatch in the same cycle is discarded.

## Timing
- Reset values:
  - `out_mem_ena`, `out_mem_iswrite`: 0.
  - `out_mem_addr`, `out_mem_data`, `out_mem_size`: 0.
  - `out_ls_cdb_rob_tag`, `out_ls_cdb_value`: 0.
  - `head = tail = 0`, `count = 0`, FSM in IDLE, all entries invalid.
- `out_lsq_ok` is combinational: `count < LSQ_SIZE-1`. This leaves one slot of slack for registered dispatch.
- Issue: the request is registered one cycle after the head entry becomes eligible.
- `out_mem_ena` stays high from issue until the cycle in which `in_mem_ready` is seen; it is low the following cycle.
- Load broadcast: `out_ls_cdb_*` is valid the cycle after `in_mem_ready` and returns to 0 one cycle later.
- Back-to-back: the next head entry can issue no earlier than the cycle after `in_mem_ready`.
- Simultaneous dispatch and pop: `count` is unchanged.
- Dispatch while `out_lsq_ok` is low is ignored.
- `rst` asserted mid-transaction clears everything and drops the request. The memory controller is reset by the same `rst`.

## Structure
- `constant.v` gains:
  - `LSQ_SIZE` and `LSQ_WIDTH`;
  - `LB`/`LH`/`LW`/`LBU`/`LHU`/`SB`/`SH`/`SW` funct3 codes;
  - `MEM_SIZE_*` codes.
- It reuses the existing `DATA_WIDTH`, `ROB_WIDTH`, `ZERO_ROB`, `ZERO_DATA`, `TRUE` and `FALSE`.
- One combinational sub-module, `ls_load_extend`: inputs funct3 and raw data; output the extended 32-bit value.

## Test plan
- Dispatch LW with base tag 0, base value 0x100, imm 4, tag 3 → `out_mem_addr = 0x104`, size 2, not a write. `in_mem_ready` with data 0x12345678 → next cycle `ls_cdb` tag 3, value 0x12345678.
- LB and LBU from the same address with memory data 0x80 → broadcasts 0xFFFFFF80 and 0x00000080.
- SW with data tag 5 pending; CDB broadcasts tag 5, value 0xDEAD → no memory request until `in_committed_rob_tag = rob_tag`. Then a write to the computed address with data 0xDEAD.
- Queue holds a committed SB, an uncommitted LW and an uncommitted SH; assert `in_misbranch` → only the SB issues, `count` ends at 0, and no `ls_cdb` pulse occurs.
- Fill 15 entries → `out_lsq_ok = 0`. Pop one → `ok = 1`. Continue through 40 dispatch/pop cycles to exercise pointer wrap → results stay in program order.
- LW broadcast on `ls_cdb` with tag 7 in the same cycle as dispatch of an SW whose base tag is 7 → the SW captures the base and issues correctly after commit.
